code_entry_sequencer: RTL and testbench

- Digit-entry initiator for the lock datapath; drives the lock's digit switches and enter strobe in place of a user.
- On a start request it latches a 4-digit hex code and replays it, least-significant digit first.
- Each digit is presented on a 4-bit digit bus, then qualified by a timed enter pulse.
- Used for automated unlock/change-password sequences and for bench stimulus of the lock FSM.

---
 rtl/code_entry_sequencer_pkg.sv | 28 ++
 rtl/code_entry_sequencer_seq_timer.sv | 27 ++
 rtl/code_entry_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_code_entry_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/code_entry_sequencer_pkg.sv
// Shared constants and state encoding for the code entry sequencer.
// CHECK is only reachable when SEQ_RETRY_EN is defined.
package code_entry_sequencer_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned DEF_DIGITS       = 4;
    localparam int unsigned DEF_SETUP_CYC    = 4;
    localparam int unsigned DEF_PULSE_CYC    = 8;
    localparam int unsigned DEF_GAP_CYC      = 4;
    localparam int unsigned DEF_RETRY_WAIT   = 64;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StPulse = 3'd2,
        StGap   = 3'd3,
        StFin   = 3'd4,
        StCheck = 3'd5
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_entry_sequencer_seq_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// The count stops at zero instead of wrapping.
module code_entry_sequencer_seq_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/code_entry_sequencer.sv
// Replays a latched hex code digit by digit with timed enter pulses, LSB digit first.
// Define SEQ_RETRY_EN for the unlock check / single replay feature.
module code_entry_sequencer
    import code_entry_sequencer_pkg::*;
#(
    parameter int unsigned DIGITS     = DEF_DIGITS,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
`ifdef SEQ_RETRY_EN
    parameter int unsigned RETRY_WAIT = DEF_RETRY_WAIT,
`endif
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DIGIT_W*DIGITS-1:0] code,
`ifdef SEQ_RETRY_EN
    input  logic                      unlocked_in,
    output logic                      retry_fail,
`endif
    output logic [DIGIT_W-1:0]        sw_out,
    output logic                      enter_out,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx
);

    localparam int unsigned CODE_W = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEQ_RETRY_EN
    localparam int unsigned MAX_CYC = max3(max3(SETUP_CYC, PULSE_CYC, GAP_CYC), RETRY_WAIT, 1);
`else
    localparam int unsigned MAX_CYC = max3(SETUP_CYC, PULSE_CYC, GAP_CYC);
`endif
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIGIT_W-1:0] sw_q, sw_d, nib;
    logic               enter_q, busy_q, done_q, aborted_q, aborted_d;
    logic               load, tc;
    logic [CNT_W-1:0]   load_val;
`ifdef SEQ_RETRY_EN
    logic               attempt_q, attempt_d, fail_q, fail_d;
`endif

    code_entry_sequencer_seq_timer #(
        .WIDTH    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        aborted_d = 1'b0;
`ifdef SEQ_RETRY_EN
        attempt_d = attempt_q;
        fail_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    code_d  = code;
                    idx_d   = '0;
`ifdef SEQ_RETRY_EN
                    attempt_d = 1'b0;
`endif
                end
            end
            StSetup: if (tc) state_d = StPulse;
            StPulse: if (tc) state_d = StGap;
            StGap: begin
                if (tc) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSetup;
                    end else begin
`ifdef SEQ_RETRY_EN
                        state_d = StCheck;
`else
                        state_d = StFin;
`endif
                    end
                end
            end
`ifdef SEQ_RETRY_EN
            StCheck: begin
                if (unlocked_in) begin
                    state_d = StFin;
                end else if (tc) begin
                    if (!attempt_q) begin
                        attempt_d = 1'b1;
                        idx_d     = '0;
                        state_d   = StSetup;
                    end else begin
                        state_d = StFin;
                        fail_d  = 1'b1;
                    end
                end
            end
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort wins over every transition except the IDLE start decision.
        if (state_q != StIdle && abort) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
`ifdef SEQ_RETRY_EN
            fail_d    = 1'b0;
`endif
        end
        if (state_d == StIdle) idx_d = '0;

        nib = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == k[IDX_W-1:0]) nib = code_d[DIGIT_W*k +: DIGIT_W];
        end
        sw_d = (state_d == StIdle) ? '0 : nib;

        load     = (state_d != state_q);
        load_val = '0;
        unique case (state_d)
            StSetup: load_val = CNT_W'(SETUP_CYC - 1);
            StPulse: load_val = CNT_W'(PULSE_CYC - 1);
            StGap:   load_val = CNT_W'(GAP_CYC - 1);
`ifdef SEQ_RETRY_EN
            StCheck: load_val = CNT_W'(RETRY_WAIT - 1);
`endif
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            code_q    <= '0;
            idx_q     <= '0;
            sw_q      <= '0;
            enter_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
`ifdef SEQ_RETRY_EN
            attempt_q <= 1'b0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
            sw_q      <= sw_d;
            enter_q   <= (state_d == StPulse);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StFin);
            aborted_q <= aborted_d;
`ifdef SEQ_RETRY_EN
            attempt_q <= attempt_d;
            fail_q    <= fail_d;
`endif
        end
    end

    assign sw_out    = sw_q;
    assign enter_out = enter_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign digit_idx = idx_q;
`ifdef SEQ_RETRY_EN
    assign retry_fail = fail_q;
`endif

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Directed bench for code_entry_sequencer with default timing (4/8/4, 4 digits).
module tb_code_entry_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] code;
    logic [3:0]  sw_out;
    logic        enter_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [1:0]  digit_idx;
    logic [9:0]  obs_v;

    int errors = 0;
    int checks = 0;

    code_entry_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .code      (code),
        .sw_out    (sw_out),
        .enter_out (enter_out),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_v = {sw_out, enter_out, busy, done, aborted, digit_idx};

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sequence: t counts edges after the start-accept edge; done lands on t=64
    // (the 65th cycle), outputs clear at t=65.
    task automatic run_seq(input string name, input logic [15:0] c, input int zero_t,
                           input int again_t, input int last_t);
        logic [3:0]  e_sw;
        logic [1:0]  e_idx;
        logic        e_en, e_busy, e_done;
        int          d, j;
        code  = c;
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int t = 0; t <= last_t; t++) begin
            d = (t < 64) ? t / 16 : 3;
            j = t % 16;
            if (t <= 64) begin
                e_sw   = c[4*d +: 4];
                e_idx  = d[1:0];
                e_busy = 1'b1;
                e_en   = (t < 64) && (j >= 4) && (j < 12);
                e_done = (t == 64);
            end else begin
                e_sw = 4'h0; e_idx = 2'd0; e_busy = 1'b0; e_en = 1'b0; e_done = 1'b0;
            end
            check($sformatf("%s t=%0d", name, t), obs_v,
                  {e_sw, e_en, e_busy, e_done, 1'b0, e_idx});
            if (t == zero_t) code = 16'h0000;
            start = (t == again_t);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        code  = 16'h0000;
        #12;
        check("reset_outputs", obs_v, 10'h000);
        rst = 1'b1;
        step();
        check("idle_after_reset", obs_v, 10'h000);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        check("abort_in_idle", obs_v, 10'h000);
        abort = 1'b0;

        run_seq("basic", 16'h4321, -1, -1, 67);
        run_seq("code_change", 16'hA5C3, 12, -1, 66);
        run_seq("start_busy", 16'h4321, -1, 20, 69);

        // Abort and start together in IDLE: start is taken.
        abort = 1'b1;
        run_seq("abort_with_start", 16'h8E7F, -1, -1, 66);

        // Abort during the first digit's pulse.
        code  = 16'h4321;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("abort_pre_enter", obs_v, {4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_response", obs_v, {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        for (int i = 0; i < 70; i++) begin
            step();
            check($sformatf("post_abort_quiet %0d", i), obs_v, 10'h000);
        end
        run_seq("after_abort", 16'h4321, -1, -1, 65);

        // Asynchronous reset in the middle of a pulse.
        code  = 16'h4321;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("rst_pre_enter", {9'b0, enter_out}, 10'h001);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_enter", {9'b0, enter_out}, 10'h000);
        check("rst_async_all", obs_v, 10'h000);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("post_rst_quiet %0d", i), obs_v, 10'h000);
        end
        run_seq("after_rst", 16'hF0D2, -1, -1, 65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
